vga_sram_scheduler: RTL

//  Time-slot scheduler for the single-port 16-bit SRAM frame buffer; fetches pixels for the 640x480 VGA timing generator.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_sram_scheduler_if.sv | 28 ++
 rtl/fb_addr_gen.sv | 42 ++++
 rtl/vga_sram_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants and SRAM scheduler types.
// Shared by the scheduler top, its address generator and the writer interface.
package vga_timing_pkg;

  localparam logic [9:0] H_BLANK = 10'd160;
  localparam logic [9:0] H_TOTAL = 10'd800;
  localparam logic [9:0] V_BLANK = 10'd45;
  localparam logic [9:0] V_TOTAL = 10'd525;

  localparam int FB_AW = 18;
  localparam logic [FB_AW-1:0] FB_WORDS = 18'd153600;
  localparam logic [FB_AW-1:0] ROW_WORDS = 18'd320;

  // Read slots sit on odd columns, three ahead of the pixel they feed
  localparam logic [9:0] RD_FIRST = H_BLANK - 10'd3;
  localparam logic [9:0] RD_LAST = H_TOTAL - 10'd5;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_e;

  typedef enum logic {
    SW_IDLE,
    SW_PEND
  } swap_state_e;

  function automatic logic row_act(
    input logic [9:0] y
  );
    return (y >= V_BLANK) && (y < V_TOTAL);
  endfunction

  function automatic logic rd_slot(
    input logic [9:0] x,
    input logic [9:0] y
  );
    return row_act(y) && x[0]
      && (x >= RD_FIRST) && (x <= RD_LAST);
  endfunction

endpackage

// File: rtl/vga_sram_scheduler_if.sv
// Game-logic writer port: valid/ready request into the back buffer.
// Address is a word index relative to the back buffer base.
interface vga_sram_scheduler_if;
  import vga_timing_pkg::*;

  logic             i_wr_valid;
  logic [FB_AW-1:0] i_wr_addr;
  logic [15:0]      i_wr_data;
  logic [1:0]       i_wr_be;
  logic             o_wr_ready;

  modport master (
    output i_wr_valid,
    output i_wr_addr,
    output i_wr_data,
    output i_wr_be,
    input  o_wr_ready
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_addr,
    input  i_wr_data,
    input  i_wr_be,
    output o_wr_ready
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Frame buffer read offset: per-row base (+320 per active line)
// plus word index k within the row, no multiplier.
module fb_addr_gen
  import vga_timing_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [9:0]       i_x_cnt,
  input  logic [9:0]       i_y_cnt,
  input  logic             i_rd_slot,
  output logic [FB_AW-1:0] o_rd_off
);

  logic [FB_AW-1:0] r_row_base;
  logic [8:0]       r_k;
  logic             w_frame_start;
  logic             w_line_end;

  assign w_frame_start = (i_x_cnt == 10'd0)
    && (i_y_cnt == 10'd0);
  assign w_line_end = (i_x_cnt == H_TOTAL - 10'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row_base <= '0;
      r_k        <= '0;
    end else begin
      if (w_frame_start)
        r_row_base <= '0;
      else if (w_line_end && row_act(i_y_cnt))
        r_row_base <= r_row_base + ROW_WORDS;

      if (i_x_cnt < RD_FIRST)
        r_k <= '0;
      else if (i_rd_slot)
        r_k <= r_k + 9'd1;
    end
  end

  assign o_rd_off = r_row_base + {9'd0, r_k};

endmodule

// File: rtl/vga_sram_scheduler.sv
// Single-port SRAM slot scheduler: VGA pixel fetch on odd columns,
// writer traffic in every other slot, front/back swap at frame start.
module vga_sram_scheduler
  import vga_timing_pkg::*;
(
  input  logic                 i_clk_25M,
  input  logic                 i_rst,
  input  logic [9:0]           i_x_cnt,
  input  logic [9:0]           i_y_cnt,
  output logic [7:0]           o_pixel,
  vga_sram_scheduler_if.slave  wr,
  input  logic                 i_swap_req,
  output logic                 o_swap_done,
  output logic                 o_front_sel,
  output logic [19:0]          o_sram_addr,
  inout  wire  [15:0]          io_sram_dq,
  output logic                 o_sram_we_n,
  output logic                 o_sram_oe_n,
  output logic                 o_sram_ce_n,
  output logic                 o_sram_ub_n,
  output logic                 o_sram_lb_n
);

  swap_state_e      r_sw_state;
  swap_state_e      w_sw_next;
  logic             w_swap_now;
  logic             r_front;
  logic             w_front_nxt;
  logic             r_swap_done;

  slot_e            w_slot;
  logic             w_rd_slot;
  logic             w_ready;
  logic             w_wr_ok;
  logic [FB_AW-1:0] w_rd_off;
  logic [19:0]      w_front_base;
  logic [19:0]      w_back_base;

  logic [19:0]      r_addr;
  logic [15:0]      r_dq_out;
  logic             r_dq_oe;
  logic             r_we_n;
  logic             r_oe_n;
  logic             r_ce_n;
  logic             r_ub_n;
  logic             r_lb_n;
  logic             r_rd_act;
  logic [15:0]      r_rd_data;
  logic [7:0]       r_pixel;
  logic             w_pix_win;

  assign w_rd_slot = rd_slot(i_x_cnt, i_y_cnt);
  assign w_ready   = !i_rst && !w_rd_slot;
  assign wr.o_wr_ready = w_ready;

  // Out-of-range addresses complete the handshake but never reach the pins
  assign w_wr_ok = wr.i_wr_valid && w_ready
    && (wr.i_wr_addr < FB_WORDS);

  always_comb begin
    w_slot = SLOT_IDLE;
    unique case (1'b1)
      w_rd_slot: w_slot = SLOT_READ;
      w_wr_ok:   w_slot = SLOT_WRITE;
      default:   w_slot = SLOT_IDLE;
    endcase
  end

  always_comb begin
    w_sw_next  = r_sw_state;
    w_swap_now = 1'b0;
    unique case (r_sw_state)
      SW_IDLE: begin
        if (i_swap_req)
          w_sw_next = SW_PEND;
      end
      SW_PEND: begin
        if (i_x_cnt == 10'd0 && i_y_cnt == 10'd0) begin
          w_sw_next  = SW_IDLE;
          w_swap_now = 1'b1;
        end
      end
      default: w_sw_next = SW_IDLE;
    endcase
  end

  // Writes in the swap cycle already aim at the buffer being retired
  assign w_front_nxt  = r_front ^ w_swap_now;
  assign w_front_base = r_front ? {2'b00, FB_WORDS} : 20'd0;
  assign w_back_base  = w_front_nxt ? 20'd0 : {2'b00, FB_WORDS};

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      r_sw_state  <= SW_IDLE;
      r_front     <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_sw_state  <= w_sw_next;
      r_front     <= w_front_nxt;
      r_swap_done <= w_swap_now;
    end
  end

  fb_addr_gen u_addr (
    .i_clk     (i_clk_25M),
    .i_rst     (i_rst),
    .i_x_cnt   (i_x_cnt),
    .i_y_cnt   (i_y_cnt),
    .i_rd_slot (w_rd_slot),
    .o_rd_off  (w_rd_off)
  );

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ce_n   <= 1'b0;
      r_ub_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_rd_act <= 1'b0;
    end else begin
      r_dq_oe  <= 1'b0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ce_n   <= 1'b0;
      r_ub_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_rd_act <= 1'b0;
      unique case (w_slot)
        SLOT_READ: begin
          r_addr   <= w_front_base + {2'b00, w_rd_off};
          r_oe_n   <= 1'b0;
          r_ub_n   <= 1'b0;
          r_lb_n   <= 1'b0;
          r_rd_act <= 1'b1;
        end
        SLOT_WRITE: begin
          r_addr   <= w_back_base + {2'b00, wr.i_wr_addr};
          r_dq_out <= wr.i_wr_data;
          r_dq_oe  <= 1'b1;
          r_we_n   <= 1'b0;
          r_ub_n   <= ~wr.i_wr_be[1];
          r_lb_n   <= ~wr.i_wr_be[0];
        end
        default: ;
      endcase
    end
  end

  assign io_sram_dq = r_dq_oe ? r_dq_out : 16'hzzzz;

  // Load window runs one column ahead of the visible one
  assign w_pix_win = row_act(i_y_cnt)
    && (i_x_cnt >= H_BLANK - 10'd1)
    && (i_x_cnt <= H_TOTAL - 10'd2);

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_pixel   <= '0;
    end else begin
      if (r_rd_act)
        r_rd_data <= io_sram_dq;
      if (!w_pix_win)
        r_pixel <= '0;
      else if (i_x_cnt[0])
        r_pixel <= r_rd_data[7:0];
      else
        r_pixel <= r_rd_data[15:8];
    end
  end

  assign o_pixel     = r_pixel;
  assign o_swap_done = r_swap_done;
  assign o_front_sel = r_front;
  assign o_sram_addr = r_addr;
  assign o_sram_we_n = r_we_n;
  assign o_sram_oe_n = r_oe_n;
  assign o_sram_ce_n = r_ce_n;
  assign o_sram_ub_n = r_ub_n;
  assign o_sram_lb_n = r_lb_n;

endmodule
